booth_pp_accum: RTL and testbench
=================================

Name: booth_pp_accum

Overview:
- Receiving end of the radix-4 Booth encoding path: accepts one Booth digit per beat, LSB digit first, over a valid/ready handshake.
- Multiplies each digit by the latched multiplicand, shifts it into position and accumulates it sequentially.
- Replaces the combinational Wallace-tree reduction on area-constrained multiplier lanes.
- Delivers the signed product with a one-cycle done pulse.

Parameters:
- MBITS, 12, multiplicand width (signed two's complement); must match the ALU's MBITS.
- NBITS, 8, multiplier width (signed, even); the digit count is NBITS/2.
- COUNTBITS, 4, digit counter width; must hold NBITS/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a new product; latches mpd
- mpd  input  MBITS  signed multiplicand, sampled on accepted start
- pp_valid  input  1  pp_digit valid
- pp_digit  input  3  Booth digit, 3-bit two's complement; legal values are -2..+2
- pp_ready  output  1  block can accept a digit
- busy  output  1  accumulation in progress
- done  output  1  one-cycle pulse; prod is final
- err  output  1  sticky illegal-digit flag
- prod  output  MBITS+NBITS  signed product

Behaviour:
- Reset (async, immediate): state IDLE; pp_ready=0, busy=0, done=0, err=0, prod=0, counter=0, latched mpd=0.
- FSM has three states: IDLE, ACCUM, DONE.
- IDLE / DONE, start=1:
  - latch mpd; acc/prod cleared to 0; counter=0; err cleared; next state ACCUM.
  - In DONE, start takes priority over the return to IDLE.
- ACCUM: pp_ready=1, busy=1.
  - start is ignored; it does not restart and does not relatch mpd.
- Beat = pp_valid & pp_ready, sampled at the clock edge.
  - On each beat: acc <= acc + (sext(mpd) * digit) << (2*counter). Arithmetic is done at MBITS+NBITS bits, signed, and wraps modulo 2^(MBITS+NBITS). Legal inputs cannot overflow.
  - counter increments on each beat.
- pp_valid=0 in ACCUM: hold all state; there is no timeout.
- Last digit: a beat with counter == NBITS/2-1 moves the FSM to DONE at that edge.
  - In DONE: done=1, busy=0, pp_ready=0 for exactly one cycle, then the FSM returns to IDLE.
  - Latency is 1 cycle from the last accepted beat to done.
  - Minimum product time is NBITS/2+1 cycles after start.
- prod is the accumulator register itself. It is valid when done=1 and holds its value until the next accepted start or reset.
- Illegal digit (3'b011, 3'b100, 3'b101):
  - contributes 0 and still counts as a beat;
  - sets err=1, which stays set until the next accepted start or reset.
- pp_digit is ignored when there is no beat, including outside ACCUM.
- pp_valid outside ACCUM: no effect, no error.
- Reset asserted mid-ACCUM aborts the operation: all outputs return to reset values, and a new start is required.

Test Plan:
- Reset, then start with mpd=12'd7; send digits -1,+1,0,0 back-to-back (mpr=3) → done pulses exactly 1 cycle after the 4th beat; prod=20'd21; err=0.
- mpd=12'hFFB (-5); digits -2,0,0,0 (mpr=8'hFE) → prod=20'h0000A.
- mpd=12'h800 (-2048); digits 0,0,0,-2 (mpr=8'h80) → prod=20'h40000, no wrap.
- Backpressure: same stimulus as the first case with 2-3 idle cycles between beats, and start pulsed mid-ACCUM → prod=21; mpd unchanged; done appears only after the 4th beat.
- Illegal digit: send 3'b011 as the 2nd beat of the first case → err=1 at done; prod=20'hFFFF9 (-7); err clears on the next start.
- Reset asserted after 2 beats → all outputs are 0 immediately; a later start runs the first case cleanly to prod=21; back-to-back start in the DONE cycle is accepted.

Source files
------------

// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth partial-product accumulator: one Booth digit per beat,
// LSB digit first, each digit times the latched multiplicand is shifted into place and summed.
module booth_pp_accum #(
    parameter int MBITS     = 12,
    parameter int NBITS     = 8,
    parameter int COUNTBITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [MBITS-1:0]         mpd,
    input  logic                     pp_valid,
    input  logic [2:0]               pp_digit,
    output logic                     pp_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [MBITS+NBITS-1:0]   prod
);

    localparam int PBITS = MBITS + NBITS;
    localparam logic [COUNTBITS-1:0] LAST_DIGIT = COUNTBITS'(NBITS / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PBITS-1:0]       acc_q, acc_d;
    logic [MBITS-1:0]       mpd_q, mpd_d;
    logic [COUNTBITS-1:0]   count_q, count_d;
    logic                   err_q, err_d;

    logic                   beat;
    logic                   illegal;
    logic [PBITS-1:0]       mpd_ext;
    logic [PBITS-1:0]       multiple;
    logic [PBITS-1:0]       term;

    assign pp_ready = (state_q == ACCUM);
    assign busy     = (state_q == ACCUM);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign prod     = acc_q;

    assign beat    = pp_valid & pp_ready;
    assign mpd_ext = {{NBITS{mpd_q[MBITS-1]}}, mpd_q};

    // Digit times multiplicand; illegal encodings contribute nothing but flag err.
    always_comb begin
        multiple = '0;
        illegal  = 1'b0;
        case (pp_digit)
            3'b000:  multiple = '0;
            3'b001:  multiple = mpd_ext;
            3'b010:  multiple = mpd_ext << 1;
            3'b111:  multiple = -mpd_ext;
            3'b110:  multiple = -(mpd_ext << 1);
            default: illegal  = 1'b1;
        endcase
    end

    assign term = multiple << {count_q, 1'b0};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mpd_d   = mpd_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    state_d = ACCUM;
                    mpd_d   = mpd;
                    acc_d   = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = acc_q + term;
                    count_d = count_q + 1'b1;
                    if (illegal) begin
                        err_d = 1'b1;
                    end
                    if (count_q == LAST_DIGIT) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mpd_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mpd_q   <= mpd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_booth_pp_accum.sv
// Bench for booth_pp_accum: directed test-plan cases plus randomized products,
// checked against an arithmetic model (multiplicand times the sum of digit*4^i).
module tb_booth_pp_accum;

    localparam int MBITS = 12;
    localparam int NBITS = 8;
    localparam int PBITS = MBITS + NBITS;

    typedef logic [2:0] dig_t;
    typedef dig_t digs_t[4];

    logic             clk;
    logic             rst;
    logic             start;
    logic [MBITS-1:0] mpd;
    logic             pp_valid;
    logic [2:0]       pp_digit;
    logic             pp_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [PBITS-1:0] prod;

    int checks = 0;
    int errors = 0;

    booth_pp_accum #(.MBITS(MBITS), .NBITS(NBITS), .COUNTBITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mpd      (mpd),
        .pp_valid (pp_valid),
        .pp_digit (pp_digit),
        .pp_ready (pp_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .prod     (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_legal(input dig_t d);
        int v;
        v = int'($signed(d));
        return (v >= -2) && (v <= 2);
    endfunction

    function automatic logic [PBITS-1:0] model_prod(input logic [MBITS-1:0] m, input digs_t d);
        longint mm;
        longint s;
        mm = longint'($signed(m));
        s  = 0;
        for (int i = 0; i < 4; i++) begin
            if (is_legal(d[i])) s += longint'($signed(d[i])) * (longint'(1) << (2 * i));
        end
        return PBITS'(mm * s);
    endfunction

    function automatic bit model_err(input digs_t d);
        bit e;
        e = 1'b0;
        for (int i = 0; i < 4; i++) if (!is_legal(d[i])) e = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [MBITS-1:0] m);
        start = 1'b1;
        mpd   = m;
        tick();
        start = 1'b0;
        mpd   = MBITS'($urandom);
    endtask

    // Sends the four digits with 'gap' idle cycles before each; returns cycles waited for done.
    task automatic send_digits(input digs_t d, input int gap, input bit poke,
                               output int lat, output bit early);
        early = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap; g++) begin
                pp_valid = 1'b0;
                pp_digit = 3'($urandom);
                if (poke) begin
                    start = 1'b1;
                    mpd   = MBITS'($urandom);
                end
                tick();
                start = 1'b0;
                if (done) early = 1'b1;
            end
            pp_valid = 1'b1;
            pp_digit = d[i];
            tick();
            pp_valid = 1'b0;
            pp_digit = 3'($urandom);
            if (i < 3 && done) early = 1'b1;
        end
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mpd = '0; pp_valid = 1'b0; pp_digit = '0;
        repeat (2) tick();
        checks++;
        if ({pp_ready, busy, done, err, prod} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%0b busy=%0b done=%0b err=%0b prod=%h want all 0",
                     pp_ready, busy, done, err, prod);
        end
        rst = 1'b0;
        pp_valid = 1'b1; pp_digit = 3'b011;
        repeat (2) tick();
        pp_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || prod !== '0) begin
            errors++;
            $display("FAIL idle_valid_ignored got busy=%0b err=%0b prod=%h want 0 0 0", busy, err, prod);
        end
        $display("test_reset done");
    endtask

    task automatic run_case(input string name, input logic [MBITS-1:0] m, input digs_t d,
                            input int gap, input bit poke);
        int lat;
        bit early;
        logic [PBITS-1:0] exp_p;
        exp_p = model_prod(m, d);
        do_start(m);
        checks++;
        if (busy !== 1'b1 || pp_ready !== 1'b1 || prod !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL %s_start got busy=%0b ready=%0b prod=%h err=%0b want 1 1 0 0",
                     name, busy, pp_ready, prod, err);
        end
        send_digits(d, gap, poke, lat, early);
        checks++;
        if (lat !== 0 || early !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency got extra_wait=%0d early=%0b want 0 0", name, lat, early);
        end
        checks++;
        if (prod !== exp_p || err !== model_err(d) || busy !== 1'b0 || pp_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_result got prod=%h err=%0b busy=%0b ready=%0b want prod=%h err=%0b busy=0 ready=0",
                     name, prod, err, busy, pp_ready, exp_p, model_err(d));
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || prod !== exp_p) begin
            errors++;
            $display("FAIL %s_pulse got done=%0b busy=%0b prod=%h want 0 0 %h", name, done, busy, prod, exp_p);
        end
        $display("%s: mpd=%h prod=%h err=%0b", name, m, prod, err);
    endtask

    task automatic test_directed();
        digs_t d;
        d = '{3'b111, 3'b001, 3'b000, 3'b000};
        run_case("basic_7x3", 12'd7, d, 0, 1'b0);
        d = '{3'b110, 3'b000, 3'b000, 3'b000};
        run_case("neg5_xFE", 12'hFFB, d, 0, 1'b0);
        d = '{3'b000, 3'b000, 3'b000, 3'b110};
        run_case("min_x80", 12'h800, d, 0, 1'b0);
        checks++;
        if (prod !== 20'h40000) begin
            errors++;
            $display("FAIL min_x80_const got %h want 40000", prod);
        end
    endtask

    task automatic test_backpressure();
        digs_t d;
        d = '{3'b111, 3'b001, 3'b000, 3'b000};
        run_case("backpressure", 12'd7, d, 3, 1'b1);
        checks++;
        if (prod !== 20'd21) begin
            errors++;
            $display("FAIL backpressure_const got %h want 00015", prod);
        end
    endtask

    task automatic test_illegal();
        digs_t d;
        d = '{3'b111, 3'b011, 3'b000, 3'b000};
        run_case("illegal", 12'd7, d, 0, 1'b0);
        checks++;
        if (prod !== 20'hFFFF9 || err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_const got prod=%h err=%0b want FFFF9 1", prod, err);
        end
        do_start(12'd7);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear got err=%0b want 0", err);
        end
        rst = 1'b1; #1; rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        digs_t d;
        do_start(12'd7);
        for (int i = 0; i < 2; i++) begin
            pp_valid = 1'b1;
            pp_digit = (i == 0) ? 3'b111 : 3'b001;
            tick();
        end
        pp_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pp_ready, busy, done, err, prod} !== '0) begin
            errors++;
            $display("FAIL reset_mid got ready=%0b busy=%0b done=%0b err=%0b prod=%h want all 0",
                     pp_ready, busy, done, err, prod);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got busy=%0b want 0", busy);
        end
        d = '{3'b111, 3'b001, 3'b000, 3'b000};
        run_case("after_reset", 12'd7, d, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        digs_t d1;
        digs_t d2;
        int lat;
        bit early;
        d1 = '{3'b111, 3'b001, 3'b000, 3'b000};
        d2 = '{3'b010, 3'b111, 3'b001, 3'b110};
        do_start(12'd7);
        send_digits(d1, 0, 1'b0, lat, early);
        checks++;
        if (done !== 1'b1 || prod !== 20'd21) begin
            errors++;
            $display("FAIL b2b_first got done=%0b prod=%h want 1 00015", done, prod);
        end
        do_start(12'h123);
        checks++;
        if (busy !== 1'b1 || prod !== '0) begin
            errors++;
            $display("FAIL b2b_restart got busy=%0b prod=%h want 1 0", busy, prod);
        end
        send_digits(d2, 0, 1'b0, lat, early);
        checks++;
        if (done !== 1'b1 || lat !== 0 || prod !== model_prod(12'h123, d2)) begin
            errors++;
            $display("FAIL b2b_second got done=%0b wait=%0d prod=%h want 1 0 %h",
                     done, lat, prod, model_prod(12'h123, d2));
        end
        tick();
        $display("back_to_back: prod=%h", prod);
    endtask

    task automatic test_random();
        digs_t d;
        logic [MBITS-1:0] m;
        for (int n = 0; n < 24; n++) begin
            m = MBITS'($urandom);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) == 0) d[i] = 3'($urandom_range(3, 5));
                else d[i] = 3'(int'($urandom_range(0, 4)) - 2);
            end
            run_case($sformatf("rand%0d", n), m, d, int'($urandom_range(0, 2)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
